// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM encodings for the UART bus slave.
// UART_PARITY_EN adds the PARITY state to both serial FSMs.
package uart_pkg;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_BUSY    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_TX_DROP    = 6;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] TX_PARITY = 3'd4;
`endif

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] RX_PARITY = 3'd4;
`endif
endpackage

// File: rtl/uart_rx_core.sv
// Receive path: 2-flop synchroniser, mid-bit sampling FSM and shifter.
// UART_PARITY_EN adds an even-parity check between DATA and STOP.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // sync[1] is the synchronised line, sync[2] its previous value for edge detection
    logic [2:0]    sync;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic          par_bad;
    logic          rxd_s;

    assign rxd_s = sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync      <= 3'b111;
            state     <= RX_IDLE;
            cnt       <= '0;
            bitn      <= '0;
            par_bad   <= 1'b0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[1:0], uart_rxd};
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: if (sync[2] && !rxd_s) begin
                    state <= RX_START;
                    cnt   <= '0;
                end
                RX_START: if (cnt == HALF_END) begin
                    cnt     <= '0;
                    bitn    <= '0;
                    par_bad <= 1'b0;
                    state   <= rxd_s ? RX_IDLE : RX_DATA;
                end else cnt <= cnt + 1'b1;
                RX_DATA: if (cnt == BIT_END) begin
                    cnt     <= '0;
                    rx_byte <= {rxd_s, rx_byte[7:1]};
                    bitn    <= bitn + 1'b1;
`ifdef UART_PARITY_EN
                    if (bitn == 3'd7) state <= RX_PARITY;
`else
                    if (bitn == 3'd7) state <= RX_STOP;
`endif
                end else cnt <= cnt + 1'b1;
`ifdef UART_PARITY_EN
                RX_PARITY: if (cnt == BIT_END) begin
                    cnt     <= '0;
                    par_bad <= (rxd_s != ^rx_byte);
                    state   <= RX_STOP;
                end else cnt <= cnt + 1'b1;
`endif
                RX_STOP: if (cnt == BIT_END) begin
                    cnt   <= '0;
                    state <= RX_IDLE;
                    if (rxd_s && !par_bad) byte_done <= 1'b1;
                    else                   frame_err <= 1'b1;
                end else cnt <= cnt + 1'b1;
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_bus_slave.sv
// Memory-mapped UART target: TX FIFO + serialiser, RX holding register, STATUS/CTRL, level IRQ.
// UART_PARITY_EN selects 8E1 framing instead of 8N1.
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic       hit, wr_tx, rd_rx, wr_st, wr_ctrl;
    logic [1:0] sel, ctrl;
    logic       rx_valid, rx_overrun, frame_err, tx_drop;
    logic [7:0] rx_byte, rx_core_byte;
    logic       rx_done, rx_ferr;
    logic       unused_bits;

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel     = addr[3:2];
    assign wr_tx   = wr && hit && sel == REG_TXDATA;
    assign rd_rx   = rd && hit && sel == REG_RXDATA;
    assign wr_st   = wr && hit && sel == REG_STATUS;
    assign wr_ctrl = wr && hit && sel == REG_CTRL;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // TX FIFO
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] tx_count;
    logic        tx_full, tx_empty, tx_push, tx_pop, tx_busy;

    assign tx_full  = (tx_count == (PW+1)'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_push  = wr_tx && !tx_full;

    always_ff @(posedge clk) if (tx_push) fifo_mem[wr_ptr] <= wdata[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // TX serialiser; a pop at the end of STOP chains frames without an idle gap
    logic [2:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          bit_end;
`ifdef UART_PARITY_EN
    logic          tx_par;
`endif

    assign bit_end = (tx_cnt == BIT_END);
    assign tx_pop  = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && bit_end));
    assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state != TX_IDLE) tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_state <= TX_START;
                tx_sh    <= fifo_mem[rd_ptr];
                tx_cnt   <= '0;
                uart_txd <= 1'b0;
`ifdef UART_PARITY_EN
                tx_par   <= ^fifo_mem[rd_ptr];
`endif
            end else if (bit_end) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        uart_txd <= tx_sh[0];
                    end
                    TX_DATA: if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state <= TX_PARITY;
                        uart_txd <= tx_par;
`else
                        tx_state <= TX_STOP;
                        uart_txd <= 1'b1;
`endif
                    end else begin
                        tx_bit   <= tx_bit + 1'b1;
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        uart_txd <= tx_sh[1];
                    end
`ifdef UART_PARITY_EN
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        uart_txd <= 1'b1;
                    end
`endif
                    default: begin
                        tx_state <= TX_IDLE;
                        uart_txd <= 1'b1;
                    end
                endcase
            end
        end
    end

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .byte_done (rx_done),
        .rx_byte   (rx_core_byte),
        .frame_err (rx_ferr)
    );

    // Flag sets are ordered after W1C clears so a same-edge event is not lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
            rx_byte    <= '0;
            ctrl       <= '0;
            irqout     <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_core_byte;
                rx_valid <= 1'b1;
            end else if (rd_rx) rx_valid <= 1'b0;
            if (wr_st && wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (rx_done && rx_valid && !rd_rx) rx_overrun <= 1'b1;
            if (wr_st && wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
            if (rx_ferr) frame_err <= 1'b1;
            if (wr_st && wdata[ST_TX_DROP]) tx_drop <= 1'b0;
            if (wr_tx && tx_full) tx_drop <= 1'b1;
            if (wr_ctrl) ctrl <= wdata[1:0];
            irqout <= (ctrl[0] & rx_valid) | (ctrl[1] & ~tx_busy);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (sel)
                REG_RXDATA: rdata = {24'd0, rx_byte};
                REG_STATUS: rdata = {25'd0, tx_drop, frame_err, rx_overrun,
                                     tx_busy, tx_empty, tx_full, rx_valid};
                REG_CTRL:   rdata = {30'd0, ctrl};
                default:    rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed/randomised bench for uart_bus_slave with a frame-level reference model.
module tb_uart_bus_slave;
    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h4000_0020;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] ST   = BASE + 32'd8;
    localparam logic [31:0] CT   = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        irqout;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    int n_cmp = 0;
    int n_bad = 0;

    // reference flags, maintained from the register-level rules
    logic       m_rv = 0, m_ovr = 0, m_ferr = 0, m_drop = 0;
    logic [7:0] m_rxb = 8'd0;
    logic [31:0] v;
    logic [7:0]  b [6];
    logic [7:0]  x, y;

    uart_bus_slave #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irqout(irqout), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    function automatic int nbits();
`ifdef UART_PARITY_EN
        return 11;
`else
        return 10;
`endif
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^d;
`endif
        return stop;
    endfunction

    function automatic logic [31:0] status(input logic busy, input logic empty, input logic full);
        return {25'd0, m_drop, m_ferr, m_ovr, busy, empty, full, m_rv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // bus tasks are entered on a negedge and return on the next one
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; addr = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_rd(a, r);
        chk(tag, r, exp);
    endtask

    // entered on the first negedge where the start bit must be on the line
    task automatic tx_frame(input logic [7:0] d);
        for (int k = 0; k < nbits(); k++) begin
            chk("txd bit first cycle", uart_txd, frame_bit(d, k, 1'b1));
            repeat (CPB - 1) @(negedge clk);
            chk("txd bit last cycle", uart_txd, frame_bit(d, k, 1'b1));
            @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input logic pre_rv, input logic pre_irq);
        logic [31:0] r;
        for (int k = 0; k < nbits(); k++) begin
            uart_rxd = frame_bit(d, k, stop);
            if (k == nbits() - 1) begin
                bus_rd(ST, r);
                chk("rx_valid before stop sample", {31'd0, r[0]}, {31'd0, pre_rv});
                chk("irq before stop sample", {31'd0, irqout}, {31'd0, pre_irq});
                repeat (CPB - 1) @(negedge clk);
            end else repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        // model: a good stop bit delivers the byte, a bad one only flags
        if (stop) begin
            if (m_rv) m_ovr = 1'b1;
            m_rv = 1'b1; m_rxb = d;
        end else m_ferr = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset txd", {31'd0, uart_txd}, 32'd1);
        chk("reset irq", {31'd0, irqout}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        rd_chk("reset status", ST, status(0, 1, 0));
        rd_chk("reset ctrl", CT, 32'd0);
        rd_chk("reset rxdata", RXD, 32'd0);

        // decode
        bus_wr(CT, 32'hFFFF_FFF2);
        rd_chk("ctrl readback", CT, 32'd2);
        rd_chk("ctrl addr low bits ignored", BASE + 32'd15, 32'd2);
        bus_wr(BASE + 32'h1C, 32'd1);
        rd_chk("miss write ignored", CT, 32'd2);
        rd_chk("miss read zero", BASE + 32'h10, 32'd0);
        rd_chk("txdata reads zero", TXD, 32'd0);
        addr = CT; #1 chk("rdata zero without rd", rdata, 32'd0);
        @(negedge clk);
        bus_wr(CT, 32'd0);
        repeat (2) @(negedge clk);
        chk("irq off with ctrl 0", {31'd0, irqout}, 32'd0);

        // single TX frame
        bus_wr(TXD, 32'h0000_0155);
        chk("txd idle on write edge", {31'd0, uart_txd}, 32'd1);
        @(negedge clk);
        tx_frame(8'h55);
        rd_chk("tx idle after frame", ST, status(0, 1, 0));

        // burst of 6 writes into a 4-deep FIFO: first pops at once, sixth drops
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 6; i++) bus_wr(TXD, {24'd0, b[i]});
                m_drop = 1'b1;
                rd_chk("burst status full+drop", ST, status(1, 0, 1));
            end
            begin
                @(negedge clk);
                chk("burst txd idle before pop", {31'd0, uart_txd}, 32'd1);
                @(negedge clk);
                for (int i = 0; i < 5; i++) tx_frame(b[i]);
            end
        join
        chk("txd idle after burst", {31'd0, uart_txd}, 32'd1);
        rd_chk("burst drained", ST, status(0, 1, 0));
        bus_wr(ST, 32'h4F);
        m_drop = 1'b0;
        rd_chk("tx_drop cleared", ST, status(0, 1, 0));

        // RX single byte
        rx_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        rd_chk("rx status valid", ST, status(0, 1, 0));
        rd_chk("rxdata A3", RXD, {24'd0, m_rxb});
        m_rv = 1'b0;
        rd_chk("rx_valid cleared by read", ST, status(0, 1, 0));

        // overrun
        x = 8'($urandom); y = 8'($urandom);
        rx_frame(x, 1'b1, 1'b0, 1'b0);
        rx_frame(y, 1'b1, 1'b1, 1'b0);
        rd_chk("overrun status", ST, status(0, 1, 0));
        rd_chk("overrun keeps newest", RXD, {24'd0, y});
        m_rv = 1'b0;
        bus_wr(ST, 32'h10);
        m_ovr = 1'b0;
        rd_chk("overrun cleared", ST, status(0, 1, 0));

        // bad stop bit, then a glitch
        rx_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rd_chk("frame error", ST, status(0, 1, 0));
        bus_wr(ST, 32'h20);
        m_ferr = 1'b0;
        uart_rxd = 1'b0; @(negedge clk); uart_rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rd_chk("glitch ignored", ST, status(0, 1, 0));
        rd_chk("glitch rxdata unchanged", RXD, {24'd0, m_rxb});

        // interrupt
        bus_wr(CT, 32'd3);
        chk("irq latency pre", {31'd0, irqout}, 32'd0);
        @(negedge clk);
        chk("irq tx idle", {31'd0, irqout}, 32'd1);
        bus_wr(CT, 32'd1);
        chk("irq hold one cycle", {31'd0, irqout}, 32'd1);
        @(negedge clk);
        chk("irq off ctrl 1", {31'd0, irqout}, 32'd0);
        x = 8'($urandom);
        rx_frame(x, 1'b1, 1'b0, 1'b0);
        chk("irq on rx byte", {31'd0, irqout}, 32'd1);

        // reset mid-frame
        bus_wr(TXD, 32'd0);
        repeat (40) @(negedge clk);
        chk("txd low mid-frame", {31'd0, uart_txd}, 32'd0);
        #2 reset = 1'b0;
        #1 chk("reset txd async", {31'd0, uart_txd}, 32'd1);
        chk("reset irq async", {31'd0, irqout}, 32'd0);
        m_rv = 0; m_ovr = 0; m_ferr = 0; m_drop = 0; m_rxb = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd_chk("post reset status", ST, status(0, 1, 0));
        rd_chk("post reset ctrl", CT, 32'd0);
        rd_chk("post reset rxdata", RXD, 32'd0);
        repeat (2 * CPB) @(negedge clk);
        chk("post reset txd idle", {31'd0, uart_txd}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
